// File: rtl/i2c_bus_monitor.sv
// rtl/i2c_bus_monitor.sv - I2C pin synchronizer, glitch filter, START/STOP detect and byte framer
module i2c_bus_monitor #(
   parameter int         SYNC_STAGES = 2,
   parameter int         FILTER_LEN  = 3,
   parameter logic [6:0] DEV_ADDR    = 7'h42
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       scl_in,
   input  logic       sda_in,
   output logic       start_cond,
   output logic       stop_cond,
   output logic       scl_rise,
   output logic       scl_fall,
   output logic [3:0] clock_count,
   output logic [7:0] rx_byte,
   output logic       byte_valid,
   output logic       address_match,
   output logic       read_bit,
   output logic       write_bit,
   output logic       bus_busy
);

   typedef enum logic {IDLE, ACTIVE} state_t;

   logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
   logic [1:0]             sync_w;
   logic [1:0]             filt_q, filt_d;
   logic [1:0]             prev_q;
   logic [3:0]             cnt_q [2];
   logic [3:0]             cnt_d [2];

   state_t      state_q, state_d;
   logic [3:0]  clock_count_q, clock_count_d;
   logic [6:0]  shift_q, shift_d;
   logic [7:0]  rx_byte_q, rx_byte_d;
   logic        first_q, first_d;
   logic        match_q, match_d;
   logic        rd_q, rd_d;
   logic        wr_q, wr_d;
   logic        start_q, stop_q, rise_q, fall_q, bv_q, bv_d;

   logic scl_f, sda_f, scl_p, sda_p;
   logic start_w, stop_w, rise_w, fall_w;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         scl_sync_q <= '1;
         sda_sync_q <= '1;
      end else begin
         scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_in};
         sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_in};
      end
   end

   assign sync_w = {scl_sync_q[SYNC_STAGES-1], sda_sync_q[SYNC_STAGES-1]};

   // Index 1 is SCL, index 0 is SDA; both lines see identical delay so ordering survives.
   always_comb begin
      filt_d = filt_q;
      for (int i = 0; i < 2; i++) begin
         cnt_d[i] = 4'd0;
         if (sync_w[i] != filt_q[i]) begin
            if (cnt_q[i] == 4'(FILTER_LEN - 1)) begin
               filt_d[i] = sync_w[i];
            end else begin
               cnt_d[i] = cnt_q[i] + 4'd1;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         filt_q   <= 2'b11;
         prev_q   <= 2'b11;
         cnt_q[0] <= 4'd0;
         cnt_q[1] <= 4'd0;
      end else begin
         filt_q   <= filt_d;
         prev_q   <= filt_q;
         cnt_q[0] <= cnt_d[0];
         cnt_q[1] <= cnt_d[1];
      end
   end

   assign scl_f   = filt_q[1];
   assign sda_f   = filt_q[0];
   assign scl_p   = prev_q[1];
   assign sda_p   = prev_q[0];
   assign start_w = scl_p & scl_f & sda_p & ~sda_f;
   assign stop_w  = scl_p & scl_f & ~sda_p & sda_f;
   assign rise_w  = ~scl_p & scl_f;
   assign fall_w  = scl_p & ~scl_f;

   always_comb begin
      state_d       = state_q;
      clock_count_d = clock_count_q;
      shift_d       = shift_q;
      rx_byte_d     = rx_byte_q;
      first_d       = first_q;
      match_d       = match_q;
      rd_d          = rd_q;
      wr_d          = wr_q;
      bv_d          = 1'b0;
      if (start_w) begin
         state_d       = ACTIVE;
         clock_count_d = 4'd0;
         first_d       = 1'b1;
         match_d       = 1'b0;
         rd_d          = 1'b0;
         wr_d          = 1'b0;
      end else if (stop_w) begin
         state_d       = IDLE;
         clock_count_d = 4'd0;
         first_d       = 1'b0;
         match_d       = 1'b0;
         rd_d          = 1'b0;
         wr_d          = 1'b0;
      end else if (state_q == ACTIVE && rise_w) begin
         if (clock_count_q == 4'd8) begin
            clock_count_d = 4'd0;
         end else begin
            shift_d       = {shift_q[5:0], sda_f};
            clock_count_d = clock_count_q + 4'd1;
            if (clock_count_q == 4'd7) begin
               rx_byte_d = {shift_q, sda_f};
               bv_d      = 1'b1;
               if (first_q) begin
                  match_d = (shift_q == DEV_ADDR);
                  rd_d    = ~sda_f;
                  wr_d    = sda_f;
                  first_d = 1'b0;
               end
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= IDLE;
         clock_count_q <= 4'd0;
         shift_q       <= 7'd0;
         rx_byte_q     <= 8'h00;
         first_q       <= 1'b0;
         match_q       <= 1'b0;
         rd_q          <= 1'b0;
         wr_q          <= 1'b0;
         bv_q          <= 1'b0;
         start_q       <= 1'b0;
         stop_q        <= 1'b0;
         rise_q        <= 1'b0;
         fall_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         clock_count_q <= clock_count_d;
         shift_q       <= shift_d;
         rx_byte_q     <= rx_byte_d;
         first_q       <= first_d;
         match_q       <= match_d;
         rd_q          <= rd_d;
         wr_q          <= wr_d;
         bv_q          <= bv_d;
         start_q       <= start_w;
         stop_q        <= stop_w;
         rise_q        <= rise_w;
         fall_q        <= fall_w;
      end
   end

   assign start_cond    = start_q;
   assign stop_cond     = stop_q;
   assign scl_rise      = rise_q;
   assign scl_fall      = fall_q;
   assign clock_count   = clock_count_q;
   assign rx_byte       = rx_byte_q;
   assign byte_valid    = bv_q;
   assign address_match = match_q;
   assign read_bit      = rd_q;
   assign write_bit     = wr_q;
   assign bus_busy      = (state_q == ACTIVE);

endmodule

// File: doc/i2c_bus_monitor.md
# i2c_bus_monitor

Oversampling front end for the I2C subordinate interface. Runs on the system clock, synchronizes and glitch-filters the raw SCL/SDA pins, and detects START/STOP conditions and SCL edges. Tracks bit position within each 9-bit frame and assembles received bytes. Decodes the address byte into the match and direction flags consumed by the downstream subordinate state machine.

## Interface
- SYNC_STAGES, 2, flops in each pin synchronizer (min 2)
- FILTER_LEN, 3, consecutive clocks a synchronized level must differ from the filtered level before it is accepted (1-15)
- DEV_ADDR, 7'h42, 7-bit subordinate address
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- scl_in  in  1  raw SCL pin level
- sda_in  in  1  raw SDA pin level
- start_cond  out  1  one-clk pulse on START or repeated START
- stop_cond  out  1  one-clk pulse on STOP
- scl_rise  out  1  one-clk pulse on filtered SCL 0->1
- scl_fall  out  1  one-clk pulse on filtered SCL 1->0
- clock_count  out  4  bit slot to be sampled on next SCL rise; 0-7 data (MSB first), 8 ack
- rx_byte  out  8  last completed byte; holds until next completion
- byte_valid  out  1  one-clk pulse when rx_byte updates
- address_match  out  1  address byte matched DEV_ADDR
- read_bit  out  1  R/W=0: subordinate receives data
- write_bit  out  1  R/W=1: subordinate transmits data
- bus_busy  out  1  high from START until STOP

## Operation
- Synchronizer: SYNC_STAGES flops per line, reset to 1.
- Filter: per-line counter and filtered level (reset 1). Counter increments while sync != filtered and clears when equal. On reaching FILTER_LEN, filtered takes the sync value and the counter clears.
- Edges: registered previous filtered values scl_d, sda_d (reset 1).
- START: scl_d=1, scl_f=1, sda_d=1, sda_f=0. STOP: scl_d=1, scl_f=1, sda_d=0, sda_f=1.
- SCL and SDA changing in the same clk: no START/STOP; only the SCL edge pulse.
- Frame tracking (states IDLE, ACTIVE):
  - START from any state -> ACTIVE; clock_count=0; first_byte=1; address_match, read_bit, write_bit cleared.
  - STOP -> IDLE; clock_count=0; first_byte=0; flags cleared; rx_byte held.
  - ACTIVE, scl_rise, clock_count<=7: shift = {shift[6:0], sda_f}; clock_count+1.
  - ACTIVE, scl_rise, clock_count=8: clock_count=0 (ack slot; SDA not shifted).
  - In IDLE, SCL edges change no counter or shift state. scl_rise/scl_fall still pulse.
- Byte completion: the scl_rise sampling slot 7 produces a byte_valid pulse and loads rx_byte with the completed byte.
  - If first_byte: address_match = (byte[7:1]==DEV_ADDR), read_bit = ~byte[0], write_bit = byte[0], first_byte=0.
  - Flags hold until the next START or STOP.
  - On mismatch, read_bit/write_bit still reflect byte[0]; downstream gates them with address_match.
- Repeated START mid-frame discards the partial byte; no byte_valid.

## Timing
- Reset values: all outputs 0 except bus_busy=0 and clock_count=0; rx_byte=8'h00; internal levels 1; state IDLE.
- All outputs are registered.
- Input-change-to-pulse latency: exactly SYNC_STAGES+FILTER_LEN+1 clk for both lines, so SCL/SDA ordering is preserved.
- Glitches shorter than FILTER_LEN clk after synchronization are rejected.
- START and scl_rise can never pulse in the same clk (START requires SCL stable high).
- byte_valid, rx_byte, clock_count, and the address flags update in the same clk as the corresponding scl_rise pulse.
- bus_busy rises with start_cond and falls with stop_cond.
- Asynchronous reset mid-transfer returns everything to reset values immediately. The bus is then treated as idle until the next START.
- Minimum clk requirement: SCL high and low phases each longer than (FILTER_LEN+2) clk.

## Test plan
- Reset with scl_in=sda_in=1, then START -> after SYNC_STAGES+FILTER_LEN+1 clk: start_cond pulses one clk, bus_busy=1, clock_count=0.
- START, address 0x42 with R/W=0 (byte 0x84), ack clock -> byte_valid once, rx_byte=8'h84, address_match=1, read_bit=1, write_bit=0; clock_count returns to 0 after the 9th rise.
- START, byte 0x85, then data byte 0xA5 -> second byte_valid with rx_byte=8'hA5; write_bit stays 1; address unchanged.
- START, address byte 0x22 -> address_match=0. STOP -> stop_cond pulse, bus_busy=0, all flags 0, rx_byte still 8'h22.
- SDA pulse of FILTER_LEN-1 clk while SCL high -> no start_cond or stop_cond. FILTER_LEN clk pulse -> both are detected.
- Repeated START after 4 data bits, then rst_n low mid-byte -> repeated START: clock_count=0, no byte_valid; reset: all outputs 0 within the same clk.
